traffic_phase_controller: RTL and testbench

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

---
 rtl/traffic_phase_controller.sv | 156 +++++++++++++++
 tb/tb_traffic_phase_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Brief    : Two-direction intersection phase sequencer with demand-driven
//            green rest and a level-sensitive flashing-yellow maintenance mode.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_controller #(
    parameter int GREEN_TIME   = 30,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       row_request,
    input  logic       column_request,
    input  logic       flash,
    output logic [2:0] row_traffic_lights,
    output logic [2:0] column_traffic_lights,
    output logic [6:0] row_count,
    output logic [6:0] column_count,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_RED_TO_ROW = 3'd0,
        S_ROW_GREEN  = 3'd1,
        S_ROW_YELLOW = 3'd2,
        S_RED_TO_COL = 3'd3,
        S_COL_GREEN  = 3'd4,
        S_COL_YELLOW = 3'd5,
        S_FLASH      = 3'd6
    } state_t;

    localparam logic [6:0] c_green   = 7'(GREEN_TIME);
    localparam logic [6:0] c_yellow  = 7'(YELLOW_TIME);
    localparam logic [6:0] c_all_red = 7'(ALL_RED_TIME);
    localparam logic [2:0] c_red     = 3'b100;
    localparam logic [2:0] c_amber   = 3'b010;
    localparam logic [2:0] c_go      = 3'b001;

    state_t     r_state, w_next_state;
    logic [6:0] r_remaining, w_next_remaining;
    logic       r_blink, w_next_blink;
    logic       r_row_pending, w_next_row_pending;
    logic       r_col_pending, w_next_col_pending;
    logic [2:0] w_next_row_lights, w_next_col_lights;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state               <= S_RED_TO_ROW;
            r_remaining           <= c_all_red;
            r_blink               <= 1'b0;
            r_row_pending         <= 1'b0;
            r_col_pending         <= 1'b0;
            row_traffic_lights    <= c_red;
            column_traffic_lights <= c_red;
        end else begin
            r_state               <= w_next_state;
            r_remaining           <= w_next_remaining;
            r_blink               <= w_next_blink;
            r_row_pending         <= w_next_row_pending;
            r_col_pending         <= w_next_col_pending;
            row_traffic_lights    <= w_next_row_lights;
            column_traffic_lights <= w_next_col_lights;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_next_blink     = r_blink;
        if (flash) begin
            w_next_state     = S_FLASH;
            w_next_remaining = 7'd0;
            w_next_blink     = (r_state == S_FLASH) ? (r_blink ^ tick) : 1'b1;
        end else if (r_state == S_FLASH) begin
            w_next_state     = S_RED_TO_ROW;
            w_next_remaining = c_all_red;
            w_next_blink     = 1'b0;
        end else if (tick) begin
            if (r_remaining != 7'd1) begin
                w_next_remaining = r_remaining - 7'd1;
            end else begin
                // Green rests at 1 until the opposing direction has demand.
                case (r_state)
                    S_RED_TO_ROW: begin
                        w_next_state     = S_ROW_GREEN;
                        w_next_remaining = c_green;
                    end
                    S_ROW_GREEN: begin
                        if (r_col_pending || column_request) begin
                            w_next_state     = S_ROW_YELLOW;
                            w_next_remaining = c_yellow;
                        end
                    end
                    S_ROW_YELLOW: begin
                        w_next_state     = S_RED_TO_COL;
                        w_next_remaining = c_all_red;
                    end
                    S_RED_TO_COL: begin
                        w_next_state     = S_COL_GREEN;
                        w_next_remaining = c_green;
                    end
                    S_COL_GREEN: begin
                        if (r_row_pending || row_request) begin
                            w_next_state     = S_COL_YELLOW;
                            w_next_remaining = c_yellow;
                        end
                    end
                    S_COL_YELLOW: begin
                        w_next_state     = S_RED_TO_ROW;
                        w_next_remaining = c_all_red;
                    end
                    default: begin
                        w_next_state     = S_RED_TO_ROW;
                        w_next_remaining = c_all_red;
                    end
                endcase
            end
        end
    end

    // Clearing on green entry takes precedence over a same-cycle request.
    always_comb begin
        w_next_row_pending = r_row_pending | row_request;
        w_next_col_pending = r_col_pending | column_request;
        if (w_next_state == S_ROW_GREEN && r_state != S_ROW_GREEN)
            w_next_row_pending = 1'b0;
        if (w_next_state == S_COL_GREEN && r_state != S_COL_GREEN)
            w_next_col_pending = 1'b0;
    end

    always_comb begin
        w_next_row_lights = c_red;
        w_next_col_lights = c_red;
        case (w_next_state)
            S_ROW_GREEN:  w_next_row_lights = c_go;
            S_ROW_YELLOW: w_next_row_lights = c_amber;
            S_COL_GREEN:  w_next_col_lights = c_go;
            S_COL_YELLOW: w_next_col_lights = c_amber;
            S_FLASH: begin
                w_next_row_lights = w_next_blink ? c_amber : 3'b000;
                w_next_col_lights = w_next_blink ? c_amber : 3'b000;
            end
            default: ;
        endcase
    end

    assign phase        = r_state;
    assign row_count    = (r_state == S_ROW_GREEN || r_state == S_ROW_YELLOW) ? r_remaining : 7'd0;
    assign column_count = (r_state == S_COL_GREEN || r_state == S_COL_YELLOW) ? r_remaining : 7'd0;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_controller
// Brief    : Randomized and directed bench against a table-driven phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, row_request = 1'b0, column_request = 1'b0, flash = 1'b0;
    logic [2:0] row_traffic_lights, column_traffic_lights, phase;
    logic [6:0] row_count, column_count;

    int total = 0;
    int bad   = 0;

    // Model: phase index 0..5 cycle with table durations/lights, 6 = flash.
    int dur    [0:5] = '{2, 30, 4, 2, 30, 4};
    int row_lt [0:5] = '{4, 1, 2, 4, 4, 4};
    int col_lt [0:5] = '{4, 4, 4, 4, 1, 2};
    int m_phase = 0, m_left = 2, m_blink = 0, m_rp = 0, m_cp = 0;

    traffic_phase_controller dut (
        .clock                 (clock),
        .reset                 (reset),
        .tick                  (tick),
        .row_request           (row_request),
        .column_request        (column_request),
        .flash                 (flash),
        .row_traffic_lights    (row_traffic_lights),
        .column_traffic_lights (column_traffic_lights),
        .row_count             (row_count),
        .column_count          (column_count),
        .phase                 (phase)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 2; m_blink = 0; m_rp = 0; m_cp = 0;
    endtask

    task automatic compare_all();
        int er, ec, erc, ecc;
        if (m_phase == 6) begin
            er = m_blink ? 2 : 0;
            ec = er;
        end else begin
            er = row_lt[m_phase];
            ec = col_lt[m_phase];
        end
        erc = (m_phase == 1 || m_phase == 2) ? m_left : 0;
        ecc = (m_phase == 4 || m_phase == 5) ? m_left : 0;
        check("phase",        int'(phase), m_phase);
        check("row_lights",   int'(row_traffic_lights), er);
        check("col_lights",   int'(column_traffic_lights), ec);
        check("row_count",    int'(row_count), erc);
        check("column_count", int'(column_count), ecc);
    endtask

    // One clock: drive at negedge, advance the model, check after the edge.
    task automatic step(input logic t, input logic rr, input logic cr,
                        input logic fl, input logic rs);
        int np, nl, nb, nrp, ncp;
        @(negedge clock);
        tick = t; row_request = rr; column_request = cr; flash = fl; reset = rs;
        np = m_phase; nl = m_left; nb = m_blink;
        if (fl) begin
            np = 6; nl = 0;
            nb = (m_phase == 6) ? (m_blink ^ int'(t)) : 1;
        end else if (m_phase == 6) begin
            np = 0; nl = dur[0]; nb = 0;
        end else if (t) begin
            if (m_left > 1) nl = m_left - 1;
            else if (m_phase == 1 && !(m_cp != 0 || cr)) nl = 1;
            else if (m_phase == 4 && !(m_rp != 0 || rr)) nl = 1;
            else begin
                np = (m_phase + 1) % 6;
                nl = dur[np];
            end
        end
        nrp = (m_rp != 0 || rr) ? 1 : 0;
        ncp = (m_cp != 0 || cr) ? 1 : 0;
        if (np == 1 && m_phase != 1) nrp = 0;
        if (np == 4 && m_phase != 4) ncp = 0;
        @(posedge clock);
        #1;
        if (rs) model_reset();
        else begin
            m_phase = np; m_left = nl; m_blink = nb; m_rp = nrp; m_cp = ncp;
        end
        compare_all();
    endtask

    // Safety watch on every falling edge.
    always @(negedge clock) begin
        check("phase_not_7", int'(phase != 3'd7), 1);
        if (phase != 3'd6)
            check("one_direction_red",
                  int'(row_traffic_lights == 3'b100 || column_traffic_lights == 3'b100), 1);
    end

    initial begin
        int fl_state;
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        check("rst_phase", int'(phase), 0);
        check("rst_row_lights", int'(row_traffic_lights), 4);
        check("rst_col_lights", int'(column_traffic_lights), 4);

        // Held column demand: 2 red ticks, full row green, yellow, red, column green.
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("red_after_1_tick", int'(row_traffic_lights), 4);
        step(1, 0, 1, 0, 0);
        check("row_green_entry", int'(row_traffic_lights), 1);
        check("row_count_full", int'(row_count), 30);
        for (int i = 0; i < 40; i++) step(1, 0, 1, 0, 0);
        check("col_green_reached", int'(column_traffic_lights), 1);

        // No demand: row green rests at 1; a lone column pulse ends it on next tick.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0);
        check("row_rest_phase", int'(phase), 1);
        check("row_rest_count", int'(row_count), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("pending_no_tick", int'(phase), 1);
        step(1, 0, 0, 0, 0);
        check("pulse_to_yellow", int'(phase), 2);

        // Request coinciding with the rest-decision tick is honoured.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("coincident_req", int'(phase), 2);

        // Async reset between edges during row yellow.
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst_phase", int'(phase), 0);
        check("async_rst_row", int'(row_traffic_lights), 4);
        check("async_rst_col", int'(column_traffic_lights), 4);
        step(1, 0, 0, 0, 1);

        // Flash mid column green at count 17, then release.
        for (int i = 0; i < 200 && !(m_phase == 4 && m_left == 17); i++) step(1, 0, 1, 0, 0);
        check("reach_col_17", int'(column_count), 17);
        step(0, 0, 0, 1, 0);
        check("flash_entry", int'(phase), 6);
        check("flash_lights", int'(column_traffic_lights), 2);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check("flash_exit", int'(phase), 0);

        // Randomized soak.
        fl_state = 0;
        for (int i = 0; i < 6000; i++) begin
            if (fl_state == 0 && $urandom_range(0, 299) == 0) fl_state = 1;
            else if (fl_state == 1 && $urandom_range(0, 15) == 0) fl_state = 0;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 11) == 0), 1'(fl_state),
                 1'($urandom_range(0, 1499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
